// File: rtl/shift_right_seq_32_if.sv
//==============================================================================
// Module  : shift_right_seq_32_if
// Purpose : start/busy/done handshake and operand/result bus of the right shifter
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface shift_right_seq_32_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start_i;
  logic [WIDTH-1:0] data_i;
  logic [SHW-1:0]   shamt_i;
  logic             arith_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] data_o;

  modport master (
    output start_i, data_i, shamt_i, arith_i,
    input  busy_o, done_o, data_o
  );

  modport slave (
    input  start_i, data_i, shamt_i, arith_i,
    output busy_o, done_o, data_o
  );
endinterface

`default_nettype wire

// File: rtl/shift_right_seq_32.sv
//==============================================================================
// Module  : shift_right_seq_32
// Purpose : multi-cycle logical/arithmetic right shifter, up to STEP bits/clock
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module shift_right_seq_32 #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 1
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  shift_right_seq_32_if.slave bus
);

  localparam logic [1:0]     C_IDLE  = 2'd0;
  localparam logic [1:0]     C_SHIFT = 2'd1;
  localparam logic [1:0]     C_DONE  = 2'd2;
  localparam logic [SHW-1:0] C_STEP  = SHW'(STEP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             fill_q,  fill_d;

  logic [SHW-1:0]        step_n;
  logic [WIDTH+STEP-1:0] ext;
  logic [WIDTH-1:0]      stepped;

  // One step of n = min(STEP, cnt) bits, chosen among STEP constant shifts
  always_comb begin
    step_n  = (cnt_q < C_STEP) ? cnt_q : C_STEP;
    ext     = {{STEP{fill_q}}, sreg_q};
    stepped = sreg_q;
    for (int i = 1; i <= STEP; i++) begin
      if (step_n == SHW'(i)) begin
        stepped = WIDTH'(ext >> i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      C_IDLE: begin
        if (bus.start_i) begin
          sreg_d  = bus.data_i;
          cnt_d   = bus.shamt_i;
          fill_d  = bus.arith_i & bus.data_i[WIDTH-1];
          state_d = (bus.shamt_i == '0) ? C_DONE : C_SHIFT;
        end
      end
      C_SHIFT: begin
        sreg_d = stepped;
        cnt_d  = cnt_q - step_n;
        if (cnt_d == '0) begin
          state_d = C_DONE;
        end
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= C_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.busy_o = (state_q == C_SHIFT) || (state_q == C_DONE);
  assign bus.done_o = (state_q == C_DONE);
  assign bus.data_o = sreg_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq_32.sv
//==============================================================================
// Module  : tb_shift_right_seq_32
// Purpose : scoreboard bench for shift_right_seq_32 with STEP=1 and STEP=4
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shift_right_seq_32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_right_seq_32_if #(.WIDTH(32), .SHW(5)) bus1 ();
  shift_right_seq_32_if #(.WIDTH(32), .SHW(5)) bus4 ();

  shift_right_seq_32 #(.WIDTH(32), .SHW(5), .STEP(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  shift_right_seq_32 #(.WIDTH(32), .SHW(5), .STEP(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int   start1 = 0, start4 = 0;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh, input logic ar);
    if (ar) return $unsigned($signed(d) >>> sh);
    return d >> sh;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest pending op
  always @(negedge clk) begin
    if (bus1.done_o) begin
      if (q1.size() == 0) check_val("dut1_spurious_done", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check_val("dut1_data", bus1.data_o, e1.data);
        check_val("dut1_latency", 32'(cyc - start1 + 1), 32'(e1.lat));
      end
    end
    if (bus4.done_o) begin
      if (q4.size() == 0) check_val("dut4_spurious_done", 32'd1, 32'd0);
      else begin
        e4 = q4.pop_front();
        check_val("dut4_data", bus4.data_o, e4.data);
        check_val("dut4_latency", 32'(cyc - start4 + 1), 32'(e4.lat));
      end
    end
  end

  task automatic drive(input int sel, input logic st, input logic [31:0] d,
                       input logic [4:0] sh, input logic ar);
    if (sel == 4) begin
      bus4.start_i = st; bus4.data_i = d; bus4.shamt_i = sh; bus4.arith_i = ar;
    end else begin
      bus1.start_i = st; bus1.data_i = d; bus1.shamt_i = sh; bus1.arith_i = ar;
    end
  endtask

  task automatic run_op(input int sel, input logic [31:0] d, input logic [4:0] sh, input logic ar);
    exp_t e;
    int   step = (sel == 4) ? 4 : 1;
    int   k;
    e.data = model(d, sh, ar);
    e.lat  = (int'(sh) + step - 1) / step + 1;
    @(negedge clk); #1;
    drive(sel, 1'b1, d, sh, ar);
    if (sel == 4) begin q4.push_back(e); start4 = cyc + 1; end
    else          begin q1.push_back(e); start1 = cyc + 1; end
    @(negedge clk); #1;
    // Scramble inputs: the running op must not see them
    drive(sel, 1'b0, ~d, ~sh, ~ar);
    check_val("busy_after_start", (sel == 4) ? bus4.busy_o : bus1.busy_o, 32'd1);
    k = 0;
    while (k < 40 && ((sel == 4) ? q4.size() : q1.size()) > 0) begin
      @(negedge clk); #1;
      k++;
    end
    check_val("done_timeout", 32'((sel == 4) ? q4.size() : q1.size()), 32'd0);
    @(negedge clk); #1;
    check_val("idle_busy", (sel == 4) ? bus4.busy_o : bus1.busy_o, 32'd0);
    check_val("hold_data", (sel == 4) ? bus4.data_o : bus1.data_o, e.data);
  endtask

  initial begin
    exp_t e;
    int   k;
    rst = 1'b1;
    drive(1, 1'b0, 32'h0, 5'd0, 1'b0);
    drive(4, 1'b0, 32'h0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("rst_data1", bus1.data_o, 32'h0);
    check_val("rst_busy1", bus1.busy_o, 32'd0);
    check_val("rst_done1", bus1.done_o, 32'd0);
    check_val("rst_data4", bus4.data_o, 32'h0);
    check_val("rst_busy4", bus4.busy_o, 32'd0);
    rst = 1'b0;

    run_op(1, 32'h8000_0000, 5'd4,  1'b0);
    run_op(1, 32'h8000_0000, 5'd4,  1'b1);
    run_op(1, 32'h1234_5678, 5'd0,  1'b1);
    run_op(1, 32'h8000_0001, 5'd31, 1'b1);
    run_op(1, 32'h8000_0001, 5'd31, 1'b0);
    run_op(1, 32'h7FFF_FFFF, 5'd7,  1'b1);
    run_op(4, 32'hF000_0000, 5'd9,  1'b1);
    run_op(4, 32'h8000_0001, 5'd31, 1'b1);
    run_op(4, 32'hCAFE_BABE, 5'd0,  1'b0);
    run_op(4, 32'hCAFE_BABE, 5'd3,  1'b1);
    run_op(4, 32'hCAFE_BABE, 5'd8,  1'b0);
    for (int i = 0; i < 6; i++) begin
      run_op(1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      run_op(4, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // Start while busy is ignored and not queued
    @(negedge clk); #1;
    drive(1, 1'b1, 32'hA5A5_0000, 5'd10, 1'b1);
    e.data = model(32'hA5A5_0000, 5'd10, 1'b1);
    e.lat  = 11;
    q1.push_back(e);
    start1 = cyc + 1;
    @(negedge clk); #1;
    drive(1, 1'b0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(negedge clk); #1;
    drive(1, 1'b1, 32'hFFFF_FFFF, 5'd1, 1'b0);
    @(negedge clk); #1;
    drive(1, 1'b0, 32'h0, 5'd0, 1'b0);
    k = 0;
    while (k < 40 && q1.size() > 0) begin
      @(negedge clk); #1;
      k++;
    end
    check_val("ignored_start_timeout", 32'(q1.size()), 32'd0);
    repeat (15) @(negedge clk);

    // Reset mid-operation aborts without a done pulse
    #1;
    drive(1, 1'b1, 32'hDEAD_BEEF, 5'd10, 1'b0);
    @(negedge clk); #1;
    drive(1, 1'b0, 32'h0, 5'd0, 1'b0);
    @(negedge clk); #1;
    drive(1, 1'b1, 32'h1111_1111, 5'd2, 1'b0);
    @(negedge clk); #1;
    drive(1, 1'b0, 32'h0, 5'd0, 1'b0);
    check_val("busy_mid_op", bus1.busy_o, 32'd1);
    repeat (2) @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", bus1.busy_o, 32'd0);
    check_val("abort_data", bus1.data_o, 32'h0);
    check_val("abort_done", bus1.done_o, 32'd0);
    repeat (15) @(negedge clk);

    run_op(1, 32'h0000_F000, 5'd12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
